// File: rtl/pkt_wr_dma_pkg.sv
// Shared definitions for the packet write DMA.
// Holds the header word field layout, descriptor width formula and FSM state encoding.
package pkt_wr_dma_pkg;

  // Header word layout: dest [3:0], pri [6:4], len (bytes) [17:7].
  localparam int unsigned DestLsb = 0;
  localparam int unsigned DestW   = 4;
  localparam int unsigned PriLsb  = 4;
  localparam int unsigned PriW    = 3;
  localparam int unsigned LenLsb  = 7;
  localparam int unsigned LenW    = 11;

  // One SRAM cell holds 8 bytes; word count is (len >> 3) + 1 including the header.
  localparam int unsigned WordShift = 3;
  localparam int unsigned RemW      = LenW - WordShift + 1;

  // Descriptor = {first_addr, cell count, pri, dest}.
  localparam int unsigned DescFixedW = DestW + PriW;

  function automatic int unsigned desc_w(int unsigned addr_w, int unsigned cnt_w);
    return addr_w + cnt_w + DescFixedW;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHead = 2'd1,
    StBody = 2'd2,
    StDesc = 2'd3
  } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for the optional statistics outputs.
// Ports: i_clk, i_rst_n (async, active-low), i_inc (count enable), o_cnt (count, sticks at max).
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pkt_wr_dma.sv
// Packet write DMA: moves packets from an input FIFO into SRAM cells taken from a free-pointer
// FIFO, links the cells together and posts a descriptor to the destination crossbar queue.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_dat/i_sop/i_eop/i_empty, o_rd_en input packet FIFO (first-word-fall-through)
//   i_fp_addr/i_fp_empty, o_fp_rd_en    free-pointer FIFO (first-word-fall-through)
//   o_mmu_wr_*, i_mmu_wr_ready          SRAM cell write request
//   o_ll_wr_en/o_ll_addr/o_ll_next      next-cell link write
//   o_cb_din, o_cb_wr_en, i_cb_full     descriptor write to one of NUM_DEST queues
//   o_err                               protocol error pulse
//   o_pkt_cnt, o_err_cnt                statistics (live only with PKT_WR_DMA_STATS_EN defined)
// Build option: PKT_WR_DMA_STATS_EN enables the saturating packet/error counters.
module pkt_wr_dma
  import pkt_wr_dma_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned NUM_DEST = 4,
  localparam int unsigned DESC_W  = desc_w(ADDR_W, CNT_W)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DATA_W-1:0]   i_dat,
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic                i_empty,
  output logic                o_rd_en,
  input  logic [ADDR_W-1:0]   i_fp_addr,
  input  logic                i_fp_empty,
  output logic                o_fp_rd_en,
  output logic                o_mmu_wr_req,
  output logic [ADDR_W-1:0]   o_mmu_wr_addr,
  output logic [DATA_W-1:0]   o_mmu_wr_dat,
  input  logic                i_mmu_wr_ready,
  output logic                o_ll_wr_en,
  output logic [ADDR_W-1:0]   o_ll_addr,
  output logic [ADDR_W-1:0]   o_ll_next,
  output logic [DESC_W-1:0]   o_cb_din,
  output logic [NUM_DEST-1:0] o_cb_wr_en,
  input  logic [NUM_DEST-1:0] i_cb_full,
  output logic                o_err,
  output logic [15:0]         o_pkt_cnt,
  output logic [15:0]         o_err_cnt
);

  state_e              r_state;
  logic [DestW-1:0]    r_dest;
  logic [PriW-1:0]     r_pri;
  logic [ADDR_W-1:0]   r_first_addr;
  logic [ADDR_W-1:0]   r_prev_addr;
  logic [RemW-1:0]     r_remaining;
  logic [CNT_W-1:0]    r_cells;
  logic [DESC_W-1:0]   r_cb_din;
  logic [NUM_DEST-1:0] r_cb_wr_en;
  logic                r_err;

  logic                w_active;
  logic                w_in_body;
  logic                w_xfer;
  logic                w_discard;
  logic [LenW-1:0]     w_len;
  logic [RemW-1:0]     w_hdr_words;
  logic [CNT_W-1:0]    w_cells_inc;
  logic                w_rem_one;
  logic                w_body_last;
  logic [NUM_DEST-1:0] w_dest_sel;
  logic                w_dest_ok;
  logic                w_dest_full;

  assign w_active  = (r_state == StHead) || (r_state == StBody);
  assign w_in_body = (r_state == StBody);
  assign w_discard = (r_state == StIdle) && !i_empty && !i_sop;

  assign o_mmu_wr_req  = w_active && !i_empty && !i_fp_empty;
  assign o_mmu_wr_addr = w_active ? i_fp_addr : '0;
  assign o_mmu_wr_dat  = w_active ? i_dat : '0;
  assign w_xfer        = o_mmu_wr_req && i_mmu_wr_ready;

  // Both FIFOs pop only on a transfer; the input FIFO also drops stray non-sop words in idle.
  assign o_rd_en    = w_xfer || w_discard;
  assign o_fp_rd_en = w_xfer;

  assign o_ll_wr_en = w_xfer && w_in_body;
  assign o_ll_addr  = w_in_body ? r_prev_addr : '0;
  assign o_ll_next  = w_in_body ? i_fp_addr : '0;

  assign w_len       = i_dat[LenLsb +: LenW];
  assign w_hdr_words = RemW'(w_len >> WordShift) + RemW'(1);
  assign w_cells_inc = (&r_cells) ? r_cells : r_cells + CNT_W'(1);
  assign w_rem_one   = (r_remaining == RemW'(1));
  assign w_body_last = w_rem_one || i_eop;

  // Out-of-range dest decodes to no select bit, which flags the descriptor as undeliverable.
  always_comb begin
    w_dest_sel = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      w_dest_sel[i] = (r_dest == DestW'(i));
    end
  end
  assign w_dest_ok   = |w_dest_sel;
  assign w_dest_full = |(w_dest_sel & i_cb_full);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_dest       <= '0;
      r_pri        <= '0;
      r_first_addr <= '0;
      r_prev_addr  <= '0;
      r_remaining  <= '0;
      r_cells      <= '0;
      r_cb_din     <= '0;
      r_cb_wr_en   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_cb_wr_en <= '0;
      unique case (r_state)
        StIdle: begin
          if (!i_empty) begin
            if (i_sop) r_state <= StHead;
            else       r_err   <= 1'b1;
          end
        end
        StHead: begin
          if (w_xfer) begin
            r_dest       <= i_dat[DestLsb +: DestW];
            r_pri        <= i_dat[PriLsb +: PriW];
            r_first_addr <= i_fp_addr;
            r_prev_addr  <= i_fp_addr;
            r_remaining  <= w_hdr_words - RemW'(1);
            r_cells      <= CNT_W'(1);
            if (w_hdr_words == RemW'(1)) begin
              r_cb_din <= {i_fp_addr, CNT_W'(1), i_dat[PriLsb +: PriW], i_dat[DestLsb +: DestW]};
              r_state  <= StDesc;
            end else begin
              r_state <= StBody;
            end
          end
        end
        StBody: begin
          if (w_xfer) begin
            r_prev_addr <= i_fp_addr;
            r_remaining <= r_remaining - RemW'(1);
            r_cells     <= w_cells_inc;
            if (w_body_last) begin
              r_cb_din <= {r_first_addr, w_cells_inc, r_pri, r_dest};
              r_state  <= StDesc;
              // Clean end only when eop lands exactly on the last expected word.
              r_err    <= !(w_rem_one && i_eop);
            end
          end
        end
        StDesc: begin
          if (!w_dest_ok) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else if (!w_dest_full) begin
            r_cb_wr_en <= w_dest_sel;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cb_din   = r_cb_din;
  assign o_cb_wr_en = r_cb_wr_en;
  assign o_err      = r_err;

`ifdef PKT_WR_DMA_STATS_EN
  sat_cnt #(
    .W (16)
  ) u_pkt_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (|r_cb_wr_en),
    .o_cnt   (o_pkt_cnt)
  );

  sat_cnt #(
    .W (16)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (r_err),
    .o_cnt   (o_err_cnt)
  );
`else
  assign o_pkt_cnt = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_wr_dma.sv
// Self-checking bench for pkt_wr_dma: FIFO models feed the DUT, expected SRAM writes, links and
// descriptors are queued when stimulus is issued and a negedge monitor pops and compares them.
module tb_pkt_wr_dma;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 11;
  localparam int unsigned CW = 8;
  localparam int unsigned ND = 4;
  localparam int unsigned DESCW = AW + CW + 7;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [DW-1:0]    i_dat;
  logic             i_sop, i_eop, i_empty, o_rd_en;
  logic [AW-1:0]    i_fp_addr;
  logic             i_fp_empty, o_fp_rd_en;
  logic             o_mmu_wr_req;
  logic [AW-1:0]    o_mmu_wr_addr;
  logic [DW-1:0]    o_mmu_wr_dat;
  logic             i_mmu_wr_ready;
  logic             o_ll_wr_en;
  logic [AW-1:0]    o_ll_addr, o_ll_next;
  logic [DESCW-1:0] o_cb_din;
  logic [ND-1:0]    o_cb_wr_en, i_cb_full;
  logic             o_err;
  logic [15:0]      o_pkt_cnt, o_err_cnt;

  always #5 i_clk = ~i_clk;

  pkt_wr_dma dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_dat          (i_dat),
    .i_sop          (i_sop),
    .i_eop          (i_eop),
    .i_empty        (i_empty),
    .o_rd_en        (o_rd_en),
    .i_fp_addr      (i_fp_addr),
    .i_fp_empty     (i_fp_empty),
    .o_fp_rd_en     (o_fp_rd_en),
    .o_mmu_wr_req   (o_mmu_wr_req),
    .o_mmu_wr_addr  (o_mmu_wr_addr),
    .o_mmu_wr_dat   (o_mmu_wr_dat),
    .i_mmu_wr_ready (i_mmu_wr_ready),
    .o_ll_wr_en     (o_ll_wr_en),
    .o_ll_addr      (o_ll_addr),
    .o_ll_next      (o_ll_next),
    .o_cb_din       (o_cb_din),
    .o_cb_wr_en     (o_cb_wr_en),
    .i_cb_full      (i_cb_full),
    .o_err          (o_err),
    .o_pkt_cnt      (o_pkt_cnt),
    .o_err_cnt      (o_err_cnt)
  );

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] dat;
  } word_t;

  word_t         in_q[$];
  logic [AW-1:0] fp_q[$];
  logic [63:0]   exp_mmu[$], exp_ll[$], exp_desc[$];
  int            xfer_cyc[$];
  int            n_cmp = 0, n_fail = 0;
  int            cyc = 0, xfer_cnt = 0, desc_cyc = -1;
  int            err_seen = 0, err_exp = 0, pkt_exp = 0;
  bit            rnd_en = 1'b0, full_force = 1'b0, in_hold = 1'b0, fp_hold = 1'b0;
  int            stall_ready = 0;
  logic          s_rd, s_fp;
  logic [ND-1:0] prev_full = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  task automatic drive();
    i_empty = (in_q.size() == 0) || in_hold;
    if (in_q.size() != 0) {i_sop, i_eop, i_dat} = in_q[0];
    else                  {i_sop, i_eop, i_dat} = '0;
    i_fp_empty = (fp_q.size() == 0) || fp_hold;
    i_fp_addr  = (fp_q.size() != 0) ? fp_q[0] : '0;
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // FIFO models: pop decisions are sampled mid-cycle, applied just after the rising edge.
  initial begin
    i_mmu_wr_ready = 1'b1;
    i_cb_full = '0;
    drive();
    forever begin
      @(negedge i_clk);
      s_rd = o_rd_en;
      s_fp = o_fp_rd_en;
      @(posedge i_clk);
      #1;
      if (s_rd && in_q.size() != 0) void'(in_q.pop_front());
      if (s_fp && fp_q.size() != 0) void'(fp_q.pop_front());
      if (stall_ready > 0) begin
        i_mmu_wr_ready = 1'b0;
        stall_ready--;
      end else begin
        i_mmu_wr_ready = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      in_hold = rnd_en && ($urandom_range(0, 5) == 0);
      fp_hold = rnd_en && ($urandom_range(0, 5) == 0);
      if (full_force)  i_cb_full = 4'b0100;
      else if (rnd_en) i_cb_full = ND'($urandom) & ND'($urandom);
      else             i_cb_full = '0;
      drive();
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_fp_rd_en)
          check("pop_without_xfer", 64'(o_mmu_wr_req & i_mmu_wr_ready), 64'd1);
        if (o_mmu_wr_req && i_mmu_wr_ready) begin
          xfer_cnt++;
          xfer_cyc.push_back(cyc);
          if (exp_mmu.size() == 0) fail_now("mmu_unexpected");
          else check("mmu_write", 64'({o_mmu_wr_addr, o_mmu_wr_dat}), exp_mmu.pop_front());
        end
        if (o_ll_wr_en) begin
          if (exp_ll.size() == 0) fail_now("link_unexpected");
          else check("link_write", 64'({o_ll_addr, o_ll_next}), exp_ll.pop_front());
        end
        if (o_cb_wr_en != '0) begin
          desc_cyc = cyc;
          check("desc_while_full", 64'(prev_full & o_cb_wr_en), 64'd0);
          if (exp_desc.size() == 0) fail_now("desc_unexpected");
          else check("descriptor", 64'({o_cb_wr_en, o_cb_din}), exp_desc.pop_front());
        end
        if (o_err) err_seen++;
        prev_full = i_cb_full;
      end
    end
  end

  // Reference model: the packet's words take consecutive free pointers; a descriptor carries
  // the number of words actually delivered.
  task automatic send_pkt(input int len, input int m, input bit no_eop, input int dest,
                          input int pri, input int abase);
    int            n = (len >> 3) + 1;
    logic [DW-1:0] w;
    logic [AW-1:0] a, first, prev;
    word_t         wd;
    first = '0;
    prev  = '0;
    for (int j = 0; j < m; j++) begin
      w = $urandom;
      if (j == 0) begin
        w[3:0]  = dest[3:0];
        w[6:4]  = pri[2:0];
        w[17:7] = len[10:0];
      end
      a = (abase >= 0) ? AW'(abase + j) : AW'($urandom);
      if (j == 0) first = a;
      else exp_ll.push_back(64'({prev, a}));
      prev = a;
      wd.sop = (j == 0);
      wd.eop = (j == m - 1) && !no_eop;
      wd.dat = w;
      in_q.push_back(wd);
      fp_q.push_back(a);
      exp_mmu.push_back(64'({a, w}));
    end
    if (n > 1 && (m < n || no_eop)) err_exp++;
    if (dest < ND) begin
      exp_desc.push_back(64'({ND'(1) << dest, first, CW'(m), pri[2:0], dest[3:0]}));
      pkt_exp++;
    end else begin
      err_exp++;
    end
  endtask

  task automatic send_garbage();
    word_t wd;
    wd.sop = 1'b0;
    wd.eop = 1'($urandom);
    wd.dat = $urandom;
    in_q.push_back(wd);
    err_exp++;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((in_q.size() != 0 || exp_mmu.size() != 0 || exp_ll.size() != 0 ||
            exp_desc.size() != 0) && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 5000) fail_now("drain_timeout");
    repeat (4) @(negedge i_clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mmu_req"}, 64'(o_mmu_wr_req), 64'd0);
    check({tag, "_rd_en"}, 64'({o_rd_en, o_fp_rd_en}), 64'd0);
    check({tag, "_ll_wr_en"}, 64'(o_ll_wr_en), 64'd0);
    check({tag, "_cb_wr_en"}, 64'(o_cb_wr_en), 64'd0);
    check({tag, "_cb_din"}, 64'(o_cb_din), 64'd0);
    check({tag, "_err"}, 64'(o_err), 64'd0);
    check({tag, "_stats"}, 64'({o_pkt_cnt, o_err_cnt}), 64'd0);
  endtask

  initial begin
    int base, t, drop, len, n, m;
    bit ne;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset");
    i_rst_n = 1'b1;

    // Two back-to-back 4-word packets: 1 word/cycle, 2-cycle gap between packets.
    xfer_cyc.delete();
    send_pkt(24, 4, 1'b0, 2, 5, 10);
    send_pkt(24, 4, 1'b0, 2, 5, 20);
    wait_drain();
    check("s1_xfer_count", 64'(xfer_cyc.size()), 64'd8);
    if (xfer_cyc.size() == 8) begin
      for (int k = 1; k < 8; k++)
        check($sformatf("s1_gap%0d", k), 64'(xfer_cyc[k] - xfer_cyc[k-1]),
              (k == 4) ? 64'd3 : 64'd1);
      check("s1_desc_latency", 64'(desc_cyc - xfer_cyc[7]), 64'd2);
    end

    // MMU not ready for 3 cycles on the second word.
    xfer_cyc.delete();
    send_pkt(24, 4, 1'b0, 2, 5, 10);
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!(o_mmu_wr_req && i_mmu_wr_ready) && t < 100);
    if (t >= 100) fail_now("s2_header_timeout");
    stall_ready = 3;
    wait_drain();
    check("s2_xfer_count", 64'(xfer_cyc.size()), 64'd4);
    if (xfer_cyc.size() == 4) begin
      check("s2_stall_gap", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd4);
      check("s2_after_gap", 64'(xfer_cyc[3] - xfer_cyc[1]), 64'd2);
    end

    // Destination queue full while the descriptor waits.
    full_force = 1'b1;
    base = xfer_cnt;
    send_pkt(24, 4, 1'b0, 2, 5, 10);
    t = 0;
    while (xfer_cnt < base + 4 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 200) fail_now("s3_xfer_timeout");
    repeat (5) @(negedge i_clk);
    check("s3_desc_held", 64'(exp_desc.size()), 64'd1);
    full_force = 1'b0;
    drop = cyc;
    wait_drain();
    check("s3_desc_cycle", 64'(desc_cyc), 64'(drop + 2));

    // Early eop (2 of 4 words) and a stray word without sop.
    send_pkt(24, 2, 1'b0, 2, 5, 30);
    send_garbage();
    wait_drain();
    check("s4_err_count", 64'(err_seen), 64'(err_exp));

    // Undeliverable dest, then reset in the middle of a packet body.
    send_pkt(8, 2, 1'b0, 7, 1, 40);
    wait_drain();
    check("s5_err_count", 64'(err_seen), 64'(err_exp));
    base = xfer_cnt;
    send_pkt(40, 6, 1'b0, 1, 3, 50);
    t = 0;
    while (xfer_cnt < base + 3 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 200) fail_now("s5_body_timeout");
    in_q.delete();
    fp_q.delete();
    i_empty = 1'b1;
    i_fp_empty = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_mmu.delete();
    exp_ll.delete();
    exp_desc.delete();
    err_seen = 0;
    err_exp = 0;
    pkt_exp = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    send_pkt(24, 4, 1'b0, 3, 2, 60);
    wait_drain();

    // Randomized traffic with random stalls, FIFO bubbles and queue backpressure.
    rnd_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_garbage();
      end else begin
        len = $urandom_range(0, 47);
        n = (len >> 3) + 1;
        m = n;
        ne = 1'b0;
        case ($urandom_range(0, 3))
          1: if (n >= 3) m = $urandom_range(2, n - 1);
          2: if (n >= 2) ne = 1'b1;
          default: ;
        endcase
        send_pkt(len, m, ne, $urandom_range(0, 5), $urandom_range(0, 7), -1);
      end
    end
    wait_drain();
    rnd_en = 1'b0;
    repeat (3) @(negedge i_clk);
    check("final_err_count", 64'(err_seen), 64'(err_exp));
`ifdef PKT_WR_DMA_STATS_EN
    check("stats_pkt_cnt", 64'(o_pkt_cnt), 64'(pkt_exp));
    check("stats_err_cnt", 64'(o_err_cnt), 64'(err_exp));
`else
    check("stats_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check("stats_err_cnt", 64'(o_err_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
